div_seq_ctrl: RTL

- Sequencing controller and iterative datapath for the integer divider used by the execute stage (div.w, mod.w, div.wu, mod.wu).
- Captures operands when the execute stage raises a divide request, runs a radix-2 restoring division with sign pre- and post-processing, and holds div_complete/results until the instruction leaves execute.
- Aborts cleanly on pipeline flush.
- Sits beside the execute stage. Its div_complete output gates the execute stage's ready_go.

---
 rtl/div_seq_ctrl.sv | 75 +++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: fixed-latency radix-2 restoring divider with sign fix-up, flush abort and execute-stage hold.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_enable,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             es_go,
  input  logic             flush,
  output logic             div_complete,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_busy
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] counter;
  logic [WIDTH-1:0] rem, quo, divisor_abs, dividend_raw;
  logic sign_q, sign_r;
  logic [WIDTH+1:0] diff;
  // Extra top bit holds the borrow; the shifted remainder itself needs WIDTH+1 bits.
  always_comb diff = {1'b0, rem, quo[WIDTH-1]} - {2'b0, divisor_abs};
  assign div_busy = (state == CALC) || (state == FIX);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div_complete <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      counter <= '0;
      rem <= '0;
      quo <= '0;
      divisor_abs <= '0;
      dividend_raw <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      div_complete <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_enable) begin
          quo <= (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          divisor_abs <= (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
          dividend_raw <= dividend;
          sign_q <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_r <= div_signed & dividend[WIDTH-1];
          rem <= '0;
          counter <= CW'(WIDTH - 1);
          state <= CALC;
        end
        CALC: begin
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH+1]};
          rem <= diff[WIDTH+1] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
          counter <= counter - 1'b1;
          if (counter == '0) state <= FIX;
        end
        FIX: begin
          quotient <= (divisor_abs == '0) ? '1 : sign_q ? -quo : quo;
          remainder <= (divisor_abs == '0) ? dividend_raw : sign_r ? -rem : rem;
          div_complete <= 1'b1;
          state <= DONE;
        end
        DONE: if (es_go) begin
          div_complete <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
